// File: rtl/logicnet_lut_loader.sv
`timescale 1ns/1ps
// Runtime-loadable LogicNet LUT neuron: serial table load into a 2^IN_BITS x OUT_BITS RAM,
// then registered single-cycle lookups. dbg_state exposes the control FSM.
module logicnet_lut_loader #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_last,
  output logic                load_done,
  output logic                load_err,
  input  logic                q_valid,
  output logic                q_ready,
  input  logic [IN_BITS-1:0]  q_addr,
  output logic                r_valid,
  output logic [OUT_BITS-1:0] r_data,
  output logic [1:0]          dbg_state
);

  // Handshakes: a beat/query transfers on a rising edge where valid & ready are both high.
  // Ready depends only on state and cfg_start, so a producer may hold valid while waiting.

  localparam int DEPTH = 1 << IN_BITS;
  localparam logic [IN_BITS:0] LAST_N = (IN_BITS+1)'(DEPTH - 1);
  localparam logic [IN_BITS:0] ONE_N  = (IN_BITS+1)'(1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [IN_BITS:0]     n, n_nxt;
  logic                 load_done_nxt, load_err_nxt;
  logic                 cfg_acc, q_acc, terminal;
  logic [IN_BITS-1:0]   wr_addr;
  logic [OUT_BITS-1:0]  mem [DEPTH];

  assign cfg_ready = (state == S_LOAD);
  assign q_ready   = (state == S_RUN) && !cfg_start;
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign q_acc     = q_valid && q_ready;
  assign terminal  = (n == LAST_N);
  assign dbg_state = state;

  // The generator enumerates entries with the first input bit as the MSB of the beat index.
  always_comb begin
    wr_addr = '0;
    for (int i = 0; i < IN_BITS; i++) begin
      wr_addr[i] = n[IN_BITS-1-i];
    end
  end

  always_comb begin
    state_nxt     = state;
    n_nxt         = n;
    load_done_nxt = 1'b0;
    load_err_nxt  = load_err;
    case (state)
      S_LOAD: begin
        if (cfg_acc) begin
          n_nxt = n + ONE_N;
          if (cfg_last && terminal) begin
            state_nxt     = S_RUN;
            load_done_nxt = 1'b1;
          end else if (cfg_last || terminal) begin
            state_nxt    = S_ERR;
            load_err_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (cfg_start) begin
          state_nxt    = S_LOAD;
          n_nxt        = '0;
          load_err_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      n         <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
    end else begin
      state     <= state_nxt;
      n         <= n_nxt;
      load_done <= load_done_nxt;
      load_err  <= load_err_nxt;
      r_valid   <= q_acc;
      if (q_acc) begin
        r_data <= mem[q_addr];
      end
    end
  end

  // Table RAM carries no reset; it is only read after a complete load.
  always_ff @(posedge clk) begin
    if (cfg_acc) begin
      mem[wr_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_logicnet_lut_loader.sv
`timescale 1ns/1ps
// Directed-plus-random bench for logicnet_lut_loader against an array model of the
// bit-reversed load order and a queue of expected lookup results.
module tb_logicnet_lut_loader;

  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 2;
  localparam int DEPTH    = 64;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_start = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [OUT_BITS-1:0] cfg_data = '0;
  logic                cfg_last = 1'b0;
  logic                load_done;
  logic                load_err;
  logic                q_valid = 1'b0;
  logic                q_ready;
  logic [IN_BITS-1:0]  q_addr = '0;
  logic                r_valid;
  logic [OUT_BITS-1:0] r_data;
  logic [1:0]          dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [OUT_BITS-1:0] stim [DEPTH];
  logic [OUT_BITS-1:0] model_tbl [DEPTH];
  logic [OUT_BITS-1:0] exp_q [$];
  int beats;

  logicnet_lut_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last),
    .load_done(load_done), .load_err(load_err),
    .q_valid(q_valid), .q_ready(q_ready), .q_addr(q_addr),
    .r_valid(r_valid), .r_data(r_data), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat index n lands at the address whose bits are n's bits in reverse order.
  function automatic int rev(input int v);
    int r = 0;
    for (int i = 0; i < IN_BITS; i++)
      if (((v >> i) & 1) != 0) r += 1 << (IN_BITS - 1 - i);
    return r;
  endfunction

  function automatic void model_commit();
    for (int k = 0; k < DEPTH; k++) model_tbl[rev(k)] = stim[k];
  endfunction

  // Drives beats from stim[]; returns at the negedge after the final accepted beat.
  task automatic load(input bit do_start, input int last_at, input bit gaps, output int nbeats);
    bit on = 1'b0;
    if (do_start) begin
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
    end
    check("cfg_ready_after_start", cfg_ready, 1);
    check("state_load", dbg_state, ST_LOAD);
    check("err_cleared_on_start", load_err, 0);
    nbeats = 0;
    forever begin
      on = gaps ? !on : 1'b1;
      cfg_valid = on;
      cfg_data  = stim[nbeats];
      cfg_last  = (nbeats == last_at);
      check("cfg_ready_in_load", cfg_ready, 1);
      @(negedge clk);
      if (on) begin
        nbeats++;
        if (nbeats - 1 == last_at || nbeats == DEPTH) break;
      end
      check("no_early_done", load_done, 0);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic expect_good_load();
    check("load_done_pulse", load_done, 1);
    check("load_err_clear", load_err, 0);
    check("state_run", dbg_state, ST_RUN);
    model_commit();
    @(negedge clk);
    check("load_done_one_cycle", load_done, 0);
  endtask

  task automatic expect_bad_load();
    check("err_set", load_err, 1);
    check("err_no_done", load_done, 0);
    check("state_err", dbg_state, ST_ERR);
    q_valid = 1'b1;
    q_addr  = 6'h2a;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("err_q_ready", q_ready, 0);
      @(negedge clk);
      check("err_held", load_err, 1);
      check("err_r_valid", r_valid, 0);
    end
    q_valid = 1'b0;
  endtask

  // Back-to-back queries; each result is checked one cycle after its request.
  task automatic query_burst(input int count, input bit rnd, input int fixed_addr);
    for (int c = 0; c < count; c++) begin
      q_valid = 1'b1;
      q_addr  = rnd ? IN_BITS'($urandom_range(0, DEPTH-1)) : IN_BITS'(fixed_addr);
      #1;
      check("q_ready_run", q_ready, 1);
      exp_q.push_back(model_tbl[q_addr]);
      @(negedge clk);
      check("r_valid", r_valid, 1);
      check("r_data", r_data, exp_q.pop_front());
    end
    q_valid = 1'b0;
    @(negedge clk);
    check("r_valid_idle", r_valid, 0);
  endtask

  initial begin
    // reset state
    #2;
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_q_ready", q_ready, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_data", r_data, 0);
    check("rst_state", dbg_state, ST_EMPTY);
    @(negedge clk);
    rst = 1'b0;
    q_valid = 1'b1;
    #1;
    check("empty_q_ready", q_ready, 0);
    q_valid = 1'b0;
    @(negedge clk);

    // counting table, contiguous beats
    for (int k = 0; k < DEPTH; k++) stim[k] = OUT_BITS'(k);
    load(1'b1, DEPTH-1, 1'b0, beats);
    check("beats_full", beats[7:0], 8'd64);
    expect_good_load();
    query_burst(1, 1'b0, 6'b100000);
    check("q20_const", r_data, 2'b01);
    query_burst(1, 1'b0, 6'b111111);
    check("q3f_const", r_data, 2'b11);

    // same table with gaps; random table queries after
    load(1'b1, DEPTH-1, 1'b1, beats);
    check("beats_gap", beats[7:0], 8'd64);
    expect_good_load();
    query_burst(16, 1'b1, 0);

    // early last on beat 10, then recover with a random table
    for (int k = 0; k < DEPTH; k++) stim[k] = OUT_BITS'($urandom);
    load(1'b1, 10, 1'b0, beats);
    check("beats_early", beats[7:0], 8'd11);
    expect_bad_load();
    load(1'b1, DEPTH-1, 1'b0, beats);
    expect_good_load();
    query_burst(16, 1'b1, 0);

    // missing last
    load(1'b1, -1, 1'b0, beats);
    check("beats_missing", beats[7:0], 8'd64);
    expect_bad_load();

    // reset at beat 30 of a load
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = stim[k];
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("midload_rst_state", dbg_state, ST_EMPTY);
    check("midload_rst_cfg_ready", cfg_ready, 0);
    check("midload_rst_err", load_err, 0);
    check("midload_rst_done", load_done, 0);
    cfg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("post_rst_q_ready", q_ready, 0);
      @(negedge clk);
      check("post_rst_r_valid", r_valid, 0);
    end
    q_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) stim[k] = OUT_BITS'(k);
    load(1'b1, DEPTH-1, 1'b0, beats);
    expect_good_load();

    // reset with a lookup result in flight
    q_valid = 1'b1;
    q_addr  = 6'h3f;
    @(posedge clk);
    #1;
    check("inflight_r_valid", r_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_drops_r_valid", r_valid, 0);
    check("rst_clears_r_data", r_data, 0);
    q_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    load(1'b1, DEPTH-1, 1'b0, beats);
    expect_good_load();

    // back-to-back queries with cfg_start on the third
    q_valid = 1'b1;
    q_addr  = 6'h00;
    @(negedge clk);
    check("b2b0_valid", r_valid, 1);
    check("b2b0_data", r_data, model_tbl[0]);
    q_addr = 6'h15;
    @(negedge clk);
    check("b2b1_valid", r_valid, 1);
    check("b2b1_data", r_data, model_tbl[6'h15]);
    q_addr = 6'h3f;
    cfg_start = 1'b1;
    #1;
    check("start_blocks_q_ready", q_ready, 0);
    @(negedge clk);
    cfg_start = 1'b0;
    q_valid = 1'b0;
    check("b2b2_rejected", r_valid, 0);
    for (int k = 0; k < DEPTH; k++) stim[k] = 2'b10;
    load(1'b0, DEPTH-1, 1'b0, beats);
    expect_good_load();
    query_burst(1, 1'b0, 6'h3f);
    check("reload_q3f_const", r_data, 2'b10);

    // random table, random burst
    for (int k = 0; k < DEPTH; k++) stim[k] = OUT_BITS'($urandom);
    load(1'b1, DEPTH-1, 1'b1, beats);
    expect_good_load();
    query_burst(40, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
